// File: rtl/ram2p_pkg.sv
// Shared constants, clear-FSM state type and lane-count helper for the pipelined 2-port BRAM.
package ram2p_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    function automatic int nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/ram2p_rd_pipe.sv
// Read-return chain: LATENCY stages of valid/data; the last stage holds its data between pulses.
module ram2p_rd_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc,
    input  logic             hold,
    input  logic [WIDTH-1:0] word,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata
);

    logic [LATENCY-1:0] vld_pipe;
    logic [LATENCY-1:0] upd_pipe;
    logic [WIDTH-1:0]   data_pipe [LATENCY];

    // Each stage captures only when the access it carries updates rdata, so the
    // final stage naturally holds across idle cycles and NO_CHANGE writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            upd_pipe <= '0;
            for (int k = 0; k < LATENCY; k++) data_pipe[k] <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | LATENCY'(acc);
            upd_pipe <= (upd_pipe << 1) | LATENCY'(acc & ~hold);
            if (acc && !hold) data_pipe[0] <= word;
            for (int k = 1; k < LATENCY; k++) begin
                if (upd_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
            end
        end
    end

    assign rvalid = vld_pipe[LATENCY-1];
    assign rdata  = data_pipe[LATENCY-1];

endmodule

// File: rtl/ram2p_bram_pipelined.sv
// True dual-port BRAM with byte enables, write modes, pipelined read return and post-reset clear.
// Optional collision monitor enabled by defining RAM2P_COLLISION_DETECT_EN.
module ram2p_bram_pipelined
    import ram2p_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    output logic                                  init_busy,
    input  logic                                  a_ce,
    input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]                 a_addr,
    input  logic [DATA_WIDTH-1:0]                 a_wdata,
    output logic [DATA_WIDTH-1:0]                 a_rdata,
    output logic                                  a_rvalid,
    input  logic                                  b_ce,
    input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0] b_we,
    input  logic [ADDR_WIDTH-1:0]                 b_addr,
    input  logic [DATA_WIDTH-1:0]                 b_wdata,
    output logic [DATA_WIDTH-1:0]                 b_rdata,
    output logic                                  b_rvalid
`ifdef RAM2P_COLLISION_DETECT_EN
    ,
    output logic                                  coll_flag,
    output logic [15:0]                           coll_count
`endif
);

    localparam int NB    = nb(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_t            state;
    logic [ADDR_WIDTH-1:0] walk;

    logic                  a_acc, b_acc, a_wr, b_wr, same;
    logic [DATA_WIDTH-1:0] a_mask, b_mask;
    logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, b_base, b_store;
    logic [DATA_WIDTH-1:0] a_ret, b_ret;
    logic                  a_hold, b_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            walk      <= '0;
            init_busy <= (CLEAR_ON_RESET != 0);
        end else if (state == ST_CLEAR) begin
            walk <= walk + ADDR_WIDTH'(1);
            if (&walk) begin
                state     <= ST_READY;
                init_busy <= 1'b0;
            end
        end
    end

    assign a_acc = a_ce && (state == ST_READY);
    assign b_acc = b_ce && (state == ST_READY);
    assign a_wr  = a_acc && (|a_we);
    assign b_wr  = b_acc && (|b_we);
    assign same  = (a_addr == b_addr);

    always_comb begin
        a_mask = '0;
        b_mask = '0;
        for (int i = 0; i < NB; i++) begin
            a_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{a_we[i]}};
            b_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{b_we[i]}};
        end
    end

    assign a_old = mem[a_addr];
    assign b_old = mem[b_addr];
    assign a_new = (a_old & ~a_mask) | (a_wdata & a_mask);
    assign b_new = (b_old & ~b_mask) | (b_wdata & b_mask);

    // On a same-address double write, B is layered over A's merged word so that
    // A's non-overlapping lanes survive and B owns the overlap.
    assign b_base  = (a_wr && same) ? a_new : b_old;
    assign b_store = (b_base & ~b_mask) | (b_wdata & b_mask);

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[walk] <= '0;
        end else begin
            if (a_wr) mem[a_addr] <= a_new;
            if (b_wr) mem[b_addr] <= b_store;
        end
    end

    always_comb begin
        a_ret  = a_old;
        b_ret  = b_old;
        a_hold = 1'b0;
        b_hold = 1'b0;
        case (WRITE_MODE)
            WM_WRITE_FIRST: begin
                if (a_wr) a_ret = a_new;
                if (b_wr) b_ret = b_new;
            end
            WM_NO_CHANGE: begin
                a_hold = a_wr;
                b_hold = b_wr;
            end
            default: ;
        endcase
    end

    ram2p_rd_pipe #(.WIDTH(DATA_WIDTH), .LATENCY(RD_LATENCY)) u_a_rd (
        .clk    (clk),
        .rst_n  (rst_n),
        .acc    (a_acc),
        .hold   (a_hold),
        .word   (a_ret),
        .rvalid (a_rvalid),
        .rdata  (a_rdata)
    );

    ram2p_rd_pipe #(.WIDTH(DATA_WIDTH), .LATENCY(RD_LATENCY)) u_b_rd (
        .clk    (clk),
        .rst_n  (rst_n),
        .acc    (b_acc),
        .hold   (b_hold),
        .word   (b_ret),
        .rvalid (b_rvalid),
        .rdata  (b_rdata)
    );

`ifdef RAM2P_COLLISION_DETECT_EN
    logic coll;
    assign coll = a_acc && b_acc && same && ((a_we | b_we) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_flag  <= 1'b0;
            coll_count <= '0;
        end else if (coll) begin
            coll_flag <= 1'b1;
            if (coll_count != 16'hFFFF) coll_count <= coll_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram2p_bram_pipelined.sv
// Three DUTs (one per write mode) share stimulus; a word/byte-level model predicts every output.
module tb_ram2p_bram_pipelined;

    localparam int DW = 32, AW = 4, BW = 8, LAT = 3, DEPTH = 16, NM = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_ce, b_ce;
    logic [3:0]  a_we, b_we, a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic [NM-1:0]       busy, a_rv, b_rv;
    logic [NM-1:0][31:0] a_rd, b_rd;
`ifdef RAM2P_COLLISION_DETECT_EN
    logic [NM-1:0]       cflag;
    logic [NM-1:0][15:0] ccnt;
`endif

    for (genvar m = 0; m < NM; m++) begin : g_dut
        ram2p_bram_pipelined #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
            .RD_LATENCY(LAT), .WRITE_MODE(m), .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .init_busy(busy[m]),
            .a_ce(a_ce), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
            .a_rdata(a_rd[m]), .a_rvalid(a_rv[m]),
            .b_ce(b_ce), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
            .b_rdata(b_rd[m]), .b_rvalid(b_rv[m])
`ifdef RAM2P_COLLISION_DETECT_EN
            , .coll_flag(cflag[m]), .coll_count(ccnt[m])
`endif
        );
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0]         due;
        logic [NM-1:0]       upd;
        logic [NM-1:0][31:0] d;
    } pend_t;

    logic [31:0] mdl_mem [DEPTH];
    pend_t       qa[$], qb[$];
    logic [31:0] exp_a [NM];
    logic [31:0] exp_b [NM];
    logic        exp_av, exp_bv, exp_busy, exp_flag, coll_pend;
    int          exp_cnt, clr_left, cyc;
    int          checks, errors;
    bit          run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    // What each write mode returns for one accepted access.
    function automatic pend_t mk(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
        pend_t p;
        p = '0;
        for (int m = 0; m < NM; m++) begin
            p.upd[m] = 1'b1;
            p.d[m]   = old;
            if (we != 4'd0) begin
                if (m == 1) p.d[m] = merge(old, wd, we);
                if (m == 2) p.upd[m] = 1'b0;
            end
        end
        return p;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int m = 0; m < NM; m++) begin
            exp_a[m] = '0;
            exp_b[m] = '0;
        end
        exp_av = 0; exp_bv = 0; exp_busy = 1;
        clr_left = DEPTH;
        exp_flag = 0; exp_cnt = 0; coll_pend = 0;
    endtask

    // Effect of the currently driven inputs at the coming clock edge.
    task automatic model_edge();
        logic        acc_a, acc_b;
        logic [31:0] old_a, old_b;
        pend_t       p;
        coll_pend = 0;
        if (!rst_n) return;
        acc_a = a_ce && (clr_left == 0);
        acc_b = b_ce && (clr_left == 0);
        old_a = mdl_mem[a_addr];
        old_b = mdl_mem[b_addr];
        if (clr_left > 0) begin
            mdl_mem[DEPTH-clr_left] = '0;
            clr_left--;
        end else begin
            if (acc_a) mdl_mem[a_addr] = merge(mdl_mem[a_addr], a_wdata, a_we);
            if (acc_b) mdl_mem[b_addr] = merge(mdl_mem[b_addr], b_wdata, b_we);
        end
        if (acc_a) begin p = mk(old_a, a_wdata, a_we); p.due = 32'(cyc + LAT); qa.push_back(p); end
        if (acc_b) begin p = mk(old_b, b_wdata, b_we); p.due = 32'(cyc + LAT); qb.push_back(p); end
        coll_pend = acc_a && acc_b && (a_addr == b_addr) && ((a_we | b_we) != 4'd0);
    endtask

    task automatic model_resolve();
        pend_t p;
        cyc++;
        exp_busy = !rst_n || (clr_left > 0);
        exp_av = 0;
        exp_bv = 0;
        if (qa.size() > 0 && qa[0].due == 32'(cyc)) begin
            p = qa.pop_front();
            exp_av = 1;
            for (int m = 0; m < NM; m++) if (p.upd[m]) exp_a[m] = p.d[m];
        end
        if (qb.size() > 0 && qb[0].due == 32'(cyc)) begin
            p = qb.pop_front();
            exp_bv = 1;
            for (int m = 0; m < NM; m++) if (p.upd[m]) exp_b[m] = p.d[m];
        end
        if (coll_pend) begin
            exp_flag = 1;
            if (exp_cnt < 65535) exp_cnt++;
        end
        coll_pend = 0;
    endtask

    task automatic cycle(input logic ace, input logic [3:0] awe, input logic [3:0] aad,
                         input logic [31:0] awd, input logic bce, input logic [3:0] bwe,
                         input logic [3:0] bad, input logic [31:0] bwd);
        a_ce = ace; a_we = awe; a_addr = aad; a_wdata = awd;
        b_ce = bce; b_we = bwe; b_addr = bad; b_wdata = bwd;
        model_edge();
        @(posedge clk);
        #1;
        model_resolve();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cycles(input int n);
        logic [3:0] aad;
        for (int i = 0; i < n; i++) begin
            aad = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0,
                  aad, $urandom,
                  $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0,
                  ($urandom_range(0, 2) == 0) ? aad : 4'($urandom_range(0, 15)), $urandom);
        end
    endtask

    // Count cycles of init_busy from release; optionally hammer both ports meanwhile.
    task automatic count_clear(input bit hammer, output int n);
        n = 0;
        while (busy[0] && n < 40) begin
            n++;
            if (hammer) cycle(1, 4'hF, 4'(n), $urandom, 1, 4'hF, 4'(~n), $urandom);
            else idle(1);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run) begin
            for (int m = 0; m < NM; m++) begin
                chk($sformatf("busy[%0d]", m), 32'(busy[m]), 32'(exp_busy));
                chk($sformatf("a_rvalid[%0d]", m), 32'(a_rv[m]), 32'(exp_av));
                chk($sformatf("b_rvalid[%0d]", m), 32'(b_rv[m]), 32'(exp_bv));
                chk($sformatf("a_rdata[%0d]", m), a_rd[m], exp_a[m]);
                chk($sformatf("b_rdata[%0d]", m), b_rd[m], exp_b[m]);
`ifdef RAM2P_COLLISION_DETECT_EN
                chk($sformatf("coll_flag[%0d]", m), 32'(cflag[m]), 32'(exp_flag));
                chk($sformatf("coll_count[%0d]", m), 32'(ccnt[m]), 32'(exp_cnt));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; run = 0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        rst_n = 0;
        a_ce = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_ce = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        model_reset();
        run = 1;
        @(posedge clk);
        #1;
        idle(3);
        for (int m = 0; m < NM; m++) begin
            chk("reset busy", 32'(busy[m]), 32'd1);
            chk("reset a_rdata", a_rd[m], 32'd0);
        end

        // Clear walk with requests that must be dropped.
        rst_n = 1;
        count_clear(1, n);
        chk("clear cycles", 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 4'(i), 0, 1, 0, 4'(15 - i), 0);
        idle(LAT);
        chk("clear a_rdata word", a_rd[0], 32'd0);

        // Byte-enable merge and exact latency.
        cycle(1, 4'hF, 4'd3, 32'h11223344, 0, 0, 0, 0);
        cycle(1, 4'b0101, 4'd3, 32'hAABBCCDD, 0, 0, 0, 0);
        idle(3);
        cycle(1, 0, 4'd3, 0, 0, 0, 0, 0);
        chk("lat+1 rvalid", 32'(a_rv[0]), 32'd0);
        idle(1);
        chk("lat+2 rvalid", 32'(a_rv[0]), 32'd0);
        idle(1);
        for (int m = 0; m < NM; m++) begin
            chk("lat+3 rvalid", 32'(a_rv[m]), 32'd1);
            chk("byte merge", a_rd[m], 32'h11BB33DD);
        end
        chk("model byte merge", mdl_mem[3], 32'h11BB33DD);

        // Same-port read-during-write per mode.
        cycle(1, 4'hF, 4'd5, 32'h12345678, 0, 0, 0, 0);
        idle(3);
        cycle(1, 0, 4'd5, 0, 0, 0, 0, 0);
        idle(3);
        cycle(1, 4'hF, 4'd5, 32'hCAFEF00D, 0, 0, 0, 0);
        idle(2);
        chk("rdw rvalid nochange", 32'(a_rv[2]), 32'd1);
        chk("rdw read_first", a_rd[0], 32'h12345678);
        chk("rdw write_first", a_rd[1], 32'hCAFEF00D);
        chk("rdw no_change", a_rd[2], 32'h12345678);

        // Cross-port double writes.
        cycle(1, 4'hF, 4'd7, 32'h0000FFFF, 1, 4'hF, 4'd7, 32'hFFFF0000);
`ifdef RAM2P_COLLISION_DETECT_EN
        chk("coll_flag first", 32'(cflag[0]), 32'd1);
        chk("coll_count first", 32'(ccnt[0]), 32'd1);
`endif
        idle(3);
        cycle(1, 0, 4'd7, 0, 1, 0, 4'd7, 0);
        idle(2);
        chk("b wins a_rdata", a_rd[0], 32'hFFFF0000);
        chk("b wins b_rdata", b_rd[2], 32'hFFFF0000);
        cycle(1, 4'b0011, 4'd9, 32'h11112222, 1, 4'b0110, 4'd9, 32'h33334444);
`ifdef RAM2P_COLLISION_DETECT_EN
        chk("coll_count second", 32'(ccnt[1]), 32'd2);
`endif
        idle(3);
        cycle(0, 0, 0, 0, 1, 0, 4'd9, 0);
        idle(2);
        chk("lane mix", b_rd[0], 32'h00334422);
        chk("model lane mix", mdl_mem[9], 32'h00334422);

        rand_cycles(1500);

        // Reset during the walk restarts it.
        rst_n = 0;
        model_reset();
        #1;
        for (int m = 0; m < NM; m++) begin
            chk("async reset a_rdata", a_rd[m], 32'd0);
            chk("async reset b_rvalid", 32'(b_rv[m]), 32'd0);
        end
        idle(2);
        rst_n = 1;
        idle(8);
        rst_n = 0;
        model_reset();
        #1;
        chk("mid-clear busy", 32'(busy[0]), 32'd1);
        chk("mid-clear a_rdata", a_rd[1], 32'd0);
        idle(1);
        rst_n = 1;
        count_clear(0, n);
        chk("restart clear cycles", 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 4'(i), 0, 1, 0, 4'(i), 0);
        rand_cycles(400);
        idle(LAT + 2);

        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
